// File: rtl/perf_counter_reader.sv
// Hardware performance counters for pipeline, icache and LSU events, readable as
// 32-bit lo/hi words over a one-outstanding-request MMIO slave.
module perf_counter_reader #(
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ifu_valid_i,
  input  logic              icache_valid_i,
  input  logic              icache_start_i,
  input  logic              icache_isHit_i,
  input  logic              lsu_ren_i,
  input  logic              lsu_wen_i,
  input  logic [31:0]       lsu_addr_i,
  input  logic              lsu_isWaiting_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wen_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o
);

  localparam int unsigned NUM_CNT = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t             state_q;
  logic               req_ready_q;
  logic               resp_valid_q;
  logic [31:0]        resp_rdata_q;
  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];
  logic               en_q;
  logic               en_d;
  logic [31:0]        shadow_q;
  logic               shadow_vld_q;
  logic [2:0]         shadow_idx_q;
  logic [31:0]        rdata_d;

  logic [NUM_CNT-1:0] event_hit;
  logic [2:0]         acc_idx;
  logic               acc_hi;
  logic               acc_cnt_space;
  logic               acc_ctrl;
  logic               accept;
  logic               lo_read;
  logic               ctrl_write;
  logic               clr_pulse;
  logic [31:0]        rd_lo;
  logic [31:0]        rd_hi;
  logic               unused_ok;

  function automatic logic [31:0] hi_word(input logic [CNT_W-1:0] v);
    logic [63:0] wide;
    wide = '0;
    wide[CNT_W-1:0] = v;
    return wide[63:32];
  endfunction

  // Slot 7 is reserved: its event bit is tied low so it stays at zero forever.
  assign event_hit = {1'b0, lsu_isWaiting_i, lsu_wen_i, lsu_ren_i,
                      icache_valid_i & icache_isHit_i, icache_start_i,
                      ifu_valid_i, 1'b1};

  assign acc_idx       = req_addr_i[5:3];
  assign acc_hi        = req_addr_i[2];
  assign acc_cnt_space = ~req_addr_i[6];
  assign acc_ctrl      = req_addr_i[6] & (req_addr_i[5:2] == 4'd0);
  assign accept        = (state_q == S_IDLE) & req_valid_i;
  assign lo_read       = accept & ~req_wen_i & acc_cnt_space & ~acc_hi;
  assign ctrl_write    = accept & req_wen_i & acc_ctrl;
  assign clr_pulse     = ctrl_write & req_wdata_i[1];
  assign en_d          = ctrl_write ? req_wdata_i[0] : en_q;

  assign rd_lo = cnt_q[acc_idx][31:0];
  assign rd_hi = hi_word(cnt_q[acc_idx]);

  assign unused_ok = ^{lsu_addr_i, req_wdata_i[31:2], req_addr_i};

  // Read data is formed from pre-increment values of the accept cycle.
  always_comb begin
    rdata_d = '0;
    if (!req_wen_i) begin
      if (acc_cnt_space) begin
        if (!acc_hi) begin
          rdata_d = rd_lo;
        end else if (shadow_vld_q && (shadow_idx_q == acc_idx)) begin
          rdata_d = shadow_q;
        end else begin
          rdata_d = rd_hi;
        end
      end else if (acc_ctrl) begin
        rdata_d = {31'b0, en_q};
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CNT; k++) begin
      cnt_d[k] = cnt_q[k] + CNT_W'(en_q & event_hit[k]);
      if (clr_pulse) begin
        cnt_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      en_q         <= 1'b1;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      shadow_idx_q <= '0;
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
      if (clr_pulse) begin
        shadow_vld_q <= 1'b0;
      end else if (lo_read) begin
        shadow_q     <= rd_hi;
        shadow_vld_q <= 1'b1;
        shadow_idx_q <= acc_idx;
      end
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            state_q      <= S_RESP;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rdata_d;
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_perf_counter_reader.sv
// Randomised self-checking bench for perf_counter_reader against a cycle-level
// behavioural model of the counters, CTRL register and hi/lo shadow.
module tb_perf_counter_reader;

  localparam int unsigned CNT_W  = 64;
  localparam int unsigned ADDR_W = 8;
  localparam logic [63:0] MASK = (CNT_W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                               : ((64'd1 << CNT_W) - 64'd1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ifu_valid = 1'b0;
  logic              icache_valid = 1'b0;
  logic              icache_start = 1'b0;
  logic              icache_isHit = 1'b0;
  logic              lsu_ren = 1'b0;
  logic              lsu_wen = 1'b0;
  logic [31:0]       lsu_addr = '0;
  logic              lsu_isWaiting = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_wen = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [31:0]       resp_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model state
  logic [63:0] mcnt [8];
  logic        men;
  logic [31:0] mshadow;
  logic        mshv;
  int          mshidx;
  logic        mbusy;

  perf_counter_reader #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .reset_i(reset),
    .ifu_valid_i(ifu_valid), .icache_valid_i(icache_valid),
    .icache_start_i(icache_start), .icache_isHit_i(icache_isHit),
    .lsu_ren_i(lsu_ren), .lsu_wen_i(lsu_wen), .lsu_addr_i(lsu_addr),
    .lsu_isWaiting_i(lsu_isWaiting),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int idx;
    idx = int'(a[5:3]);
    if (a[6]) return (a[5:2] == 4'd0) ? {31'b0, men} : 32'd0;
    if (idx == 7) return 32'd0;
    if (!a[2]) return mcnt[idx][31:0];
    if (mshv && mshidx == idx) return mshadow;
    return mcnt[idx][63:32];
  endfunction

  // Advance one clock; the model applies the rules using the inputs seen at the edge.
  task automatic tick();
    logic acc;
    int   idx;
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 8; k++) mcnt[k] = '0;
      men = 1'b1; mshv = 1'b0; mshadow = '0; mshidx = 0; mbusy = 1'b0;
    end else begin
      acc = !mbusy && req_valid;
      idx = int'(req_addr[5:3]);
      if (acc && !req_wen && !req_addr[6] && !req_addr[2]) begin
        mshadow = (idx == 7) ? 32'd0 : mcnt[idx][63:32];
        mshv = 1'b1;
        mshidx = idx;
      end
      if (men) begin
        mcnt[0] = mcnt[0] + 1;
        if (ifu_valid) mcnt[1] = mcnt[1] + 1;
        if (icache_start) mcnt[2] = mcnt[2] + 1;
        if (icache_valid && icache_isHit) mcnt[3] = mcnt[3] + 1;
        if (lsu_ren) mcnt[4] = mcnt[4] + 1;
        if (lsu_wen) mcnt[5] = mcnt[5] + 1;
        if (lsu_isWaiting) mcnt[6] = mcnt[6] + 1;
        for (int k = 0; k < 7; k++) mcnt[k] = mcnt[k] & MASK;
      end
      if (acc && req_wen && req_addr[6] && req_addr[5:2] == 4'd0) begin
        men = req_wdata[0];
        if (req_wdata[1]) begin
          for (int k = 0; k < 8; k++) mcnt[k] = '0;
          mshv = 1'b0;
        end
      end
      if (acc) mbusy = 1'b1;
      else if (mbusy && resp_ready) mbusy = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic set_events(input logic [6:0] ev);
    ifu_valid     = ev[0];
    icache_start  = ev[1];
    icache_valid  = ev[2];
    icache_isHit  = ev[3];
    lsu_ren       = ev[4];
    lsu_wen       = ev[5];
    lsu_isWaiting = ev[6];
  endtask

  // One full transaction with resp_ready high; ok reports the 1-cycle handshake timing.
  task automatic bus_xfer(input logic wen, input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] data, output logic [31:0] exp, output logic ok);
    logic pre_ready, pre_valid;
    exp = wen ? 32'd0 : model_read(addr);
    pre_ready = req_ready;
    pre_valid = resp_valid;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0; req_wen = 1'b0;
    data = resp_rdata;
    ok = (pre_ready === 1'b1) && (pre_valid === 1'b0) && (resp_valid === 1'b1) && (req_ready === 1'b0);
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    logic ok;
    reset = 1'b1;
    tick(); tick();
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got ready=%b valid=%b rdata=%h, want 1 0 0", req_ready, resp_valid, resp_rdata);
    end
    reset = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    bus_xfer(1'b0, 8'h00, 32'd0, d, e, ok);
    tests_run++;
    if (!ok || d !== 32'd11 || e !== 32'd11) begin
      tests_failed++;
      $display("[TB] FAIL reset_cycles: got %0d ok=%b, want 11 (model %0d)", d, ok, e);
    end
    bus_xfer(1'b0, 8'h40, 32'd0, d, e, ok);
    tests_run++;
    if (!ok || d !== 32'd1) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got %h ok=%b, want 1", d, ok);
    end
  endtask

  task automatic test_events();
    logic [31:0] d, e;
    logic ok;
    logic [7:0] addrs [3];
    logic [31:0] want [3];
    bus_xfer(1'b1, 8'h40, 32'h3, d, e, ok);
    for (int i = 0; i < 7; i++) begin
      set_events({3'b000, (i < 3) ? 2'b11 : 2'b00, (i < 5), 1'b1});
      tick();
    end
    set_events(7'b000_1000);
    tick();
    set_events('0);
    addrs[0] = 8'h10; addrs[1] = 8'h18; addrs[2] = 8'h08;
    want[0] = 32'd5; want[1] = 32'd3; want[2] = 32'd7;
    for (int i = 0; i < 3; i++) begin
      bus_xfer(1'b0, addrs[i], 32'd0, d, e, ok);
      tests_run++;
      if (!ok || d !== want[i]) begin
        tests_failed++;
        $display("[TB] FAIL events_%h: got %0d ok=%b, want %0d", addrs[i], d, ok, want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    logic ok;
    logic [7:0] a;
    for (int i = 0; i < 40; i++) begin
      set_events(7'($urandom));
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
      a = 8'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) begin
        bus_xfer(1'b1, a, $urandom, d, e, ok);
      end else begin
        bus_xfer(1'b0, a, 32'd0, d, e, ok);
      end
      tests_run++;
      if (!ok || d !== e) begin
        tests_failed++;
        $display("[TB] FAIL random_addr_%h: got %h ok=%b, want %h", a, d, ok, e);
      end
    end
    set_events('0);
    bus_xfer(1'b1, 8'h40, 32'h1, d, e, ok);
  endtask

  task automatic test_hilo();
    logic [31:0] d, e;
    logic ok;
    set_events('0);
    dut.cnt_q[4] = CNT_W'(64'h0000_0000_FFFF_FFFF);
    mcnt[4] = 64'h0000_0000_FFFF_FFFF;
    bus_xfer(1'b0, 8'h20, 32'd0, d, e, ok);
    tests_run++;
    if (!ok || d !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("[TB] FAIL hilo_lo: got %h ok=%b, want ffffffff", d, ok);
    end
    set_events(7'b001_0000);
    tick(); tick(); tick();
    set_events('0);
    bus_xfer(1'b0, 8'h24, 32'd0, d, e, ok);
    tests_run++;
    if (!ok || d !== 32'd0 || e !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL hilo_shadow: got %h ok=%b, want 0", d, ok);
    end
    bus_xfer(1'b0, 8'h24, 32'd0, d, e, ok);
    tests_run++;
    if (!ok || d !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL hilo_shadow_kept: got %h ok=%b, want 0", d, ok);
    end
    bus_xfer(1'b0, 8'h00, 32'd0, d, e, ok);
    bus_xfer(1'b0, 8'h24, 32'd0, d, e, ok);
    tests_run++;
    if (!ok || d !== 32'd1) begin
      tests_failed++;
      $display("[TB] FAIL hilo_fresh: got %h ok=%b, want 1", d, ok);
    end
  endtask

  task automatic test_enable();
    logic [31:0] d, e;
    logic ok;
    bus_xfer(1'b1, 8'h40, 32'h0, d, e, ok);
    for (int i = 0; i < 20; i++) begin
      set_events(7'($urandom));
      tick();
    end
    set_events('0);
    for (int k = 0; k < 8; k++) begin
      bus_xfer(1'b0, 8'(k * 8), 32'd0, d, e, ok);
      tests_run++;
      if (!ok || d !== e) begin
        tests_failed++;
        $display("[TB] FAIL frozen_cnt%0d: got %h ok=%b, want %h", k, d, ok, e);
      end
    end
    bus_xfer(1'b1, 8'h40, 32'h3, d, e, ok);
    for (int k = 0; k < 7; k++) begin
      bus_xfer(1'b0, 8'(k * 8), 32'd0, d, e, ok);
      tests_run++;
      if (!ok || d !== e || (k > 0 && d !== 32'd0)) begin
        tests_failed++;
        $display("[TB] FAIL cleared_cnt%0d: got %h ok=%b, want %h", k, d, ok, e);
      end
    end
    bus_xfer(1'b0, 8'h40, 32'd0, d, e, ok);
    tests_run++;
    if (!ok || d !== 32'd1) begin
      tests_failed++;
      $display("[TB] FAIL ctrl_readback: got %h ok=%b, want 1", d, ok);
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    e = model_read(8'h08);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 8'h08;
    tick();
    req_addr = 8'h10;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== e) begin
        tests_failed++;
        $display("[TB] FAIL stall_%0d: got valid=%b ready=%b rdata=%h, want 1 0 %h", i, resp_valid, req_ready, resp_rdata, e);
      end
      tick();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    tests_run++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: got valid=%b ready=%b, want 0 1", resp_valid, req_ready);
    end
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 8'h00;
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    resp_ready = 1'b1;
    tests_run++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_resp: got valid=%b ready=%b, want 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d, e;
    logic ok;
    logic [7:0] addrs [5];
    set_events('0);
    dut.cnt_q[6] = '1;
    mcnt[6] = MASK;
    set_events(7'b100_0000);
    tick();
    set_events('0);
    addrs[0] = 8'h30; addrs[1] = 8'h34; addrs[2] = 8'h38; addrs[3] = 8'h3C; addrs[4] = 8'h44;
    for (int i = 0; i < 5; i++) begin
      bus_xfer(1'b0, addrs[i], 32'd0, d, e, ok);
      tests_run++;
      if (!ok || d !== 32'd0 || e !== 32'd0) begin
        tests_failed++;
        $display("[TB] FAIL wrap_zero_%h: got %h ok=%b, want 0", addrs[i], d, ok);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) mcnt[k] = '0;
    men = 1'b1; mshv = 1'b0; mshadow = '0; mshidx = 0; mbusy = 1'b0;
    @(negedge clk);
    test_reset();
    test_events();
    test_random();
    test_hilo();
    test_enable();
    test_stall();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
